// File: rtl/sgdmac_desc_fetch_if.sv
// Descriptor-fetch bus bundle: AXI read address/data channels towards memory plus the
// descriptor valid/ready handshake towards the data-mover engine.
// Signal suffixes give the direction as seen from the fetch block.
//   master : the fetch block (drives AR, rready, desc_*)
//   slave  : memory / engine side
interface sgdmac_desc_fetch_if;
    // AXI read address channel
    logic [31:0] araddr_o;
    logic [3:0]  arlen_o;
    logic [2:0]  arsize_o;
    logic [1:0]  arburst_o;
    logic        arvalid_o;
    logic        arready_i;
    // AXI read data channel
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rlast_i;
    logic        rvalid_i;
    logic        rready_o;
    // Descriptor handoff to the engine
    logic        desc_valid_o;
    logic        desc_ready_i;
    logic [31:0] desc_src_o;
    logic [31:0] desc_dst_o;
    logic [31:0] desc_len_o;

    modport master (
        output araddr_o, arlen_o, arsize_o, arburst_o, arvalid_o,
        input  arready_i,
        input  rdata_i, rresp_i, rlast_i, rvalid_i,
        output rready_o,
        output desc_valid_o, desc_src_o, desc_dst_o, desc_len_o,
        input  desc_ready_i
    );

    modport slave (
        input  araddr_o, arlen_o, arsize_o, arburst_o, arvalid_o,
        output arready_i,
        output rdata_i, rresp_i, rlast_i, rvalid_i,
        input  rready_o,
        input  desc_valid_o, desc_src_o, desc_dst_o, desc_len_o,
        output desc_ready_i
    );
endinterface

// File: rtl/sgdmac_desc_fetch.sv
// Descriptor fetch and list-walk engine of the scatter-gather DMA.
// Reads 16-byte descriptors {src, dst, len, next} with one 4-beat INCR burst each, hands
// non-empty ones to the engine, and follows next pointers until next == 0.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start_i           one-cycle start pulse (only honoured when idle)
//   start_pointer_i   byte address of the first descriptor (0 = empty list)
//   done_o            high while idle
//   err_o             sticky: last run aborted on an AXI read error
//   desc_cnt_o        descriptors accepted by the engine this run (saturating)
//   engine_done_i     engine finished the current descriptor
//   bus               AXI read channels and descriptor handshake (master side)
module sgdmac_desc_fetch (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [31:0]                start_pointer_i,
    output logic                       done_o,
    output logic                       err_o,
    output logic [15:0]                desc_cnt_o,
    input  logic                       engine_done_i,
    sgdmac_desc_fetch_if.master        bus
);

    typedef enum logic [2:0] {StIdle, StAr, StRd, StPush, StWait} state_e;

    state_e      state_q, state_d;
    logic [27:0] ptr_q, ptr_d;      // descriptor base, 16-byte granule
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [31:0] len_q, len_d;
    logic [31:0] next_q, next_d;
    logic [1:0]  beat_q, beat_d;
    logic        err_pend_q, err_pend_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;

    logic r_fire;
    logic err_seen;

    assign r_fire   = (state_q == StRd) && bus.rvalid_i;
    // Error from an earlier beat or from the beat being accepted now.
    assign err_seen = err_pend_q || (bus.rresp_i != 2'b00);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. len_d/next_d already include the beat accepted this cycle, so the
    // decision on the rlast beat sees the complete descriptor.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i && (start_pointer_i != 32'd0)) state_d = StAr;
            end
            StAr: begin
                if (bus.arready_i) state_d = StRd;
            end
            StRd: begin
                if (r_fire && bus.rlast_i) begin
                    if (err_seen)                state_d = StIdle;
                    else if (len_d != 32'd0)     state_d = StPush;
                    else if (next_d == 32'd0)    state_d = StIdle;
                    else                         state_d = StAr;
                end
            end
            StPush: begin
                if (bus.desc_ready_i) state_d = StWait;
            end
            StWait: begin
                if (engine_done_i) state_d = (next_q == 32'd0) ? StIdle : StAr;
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state
    always_comb begin
        ptr_d      = ptr_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        next_d     = next_q;
        beat_d     = beat_q;
        err_pend_d = err_pend_q;
        err_d      = err_q;
        cnt_d      = cnt_q;

        if ((state_q == StIdle) && start_i) begin
            err_d = 1'b0;
            cnt_d = 16'd0;
            if (start_pointer_i != 32'd0) ptr_d = start_pointer_i[31:4];
        end

        if (state_q == StAr) begin
            beat_d     = 2'd0;
            err_pend_d = 1'b0;
        end

        if (r_fire) begin
            beat_d = beat_q + 2'd1;
            if (bus.rresp_i != 2'b00) err_pend_d = 1'b1;
            // Capture by beat index; a short burst leaves the remaining fields untouched.
            unique case (beat_q)
                2'd0: src_d  = bus.rdata_i;
                2'd1: dst_d  = bus.rdata_i;
                2'd2: len_d  = bus.rdata_i;
                2'd3: next_d = bus.rdata_i;
            endcase
            if (bus.rlast_i) begin
                if (err_seen) begin
                    err_d = 1'b1;
                end else if ((len_d == 32'd0) && (next_d != 32'd0)) begin
                    ptr_d = next_d[31:4];
                end
            end
        end

        if ((state_q == StPush) && bus.desc_ready_i && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end

        if ((state_q == StWait) && engine_done_i && (next_q != 32'd0)) begin
            ptr_d = next_q[31:4];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q      <= 28'd0;
            src_q      <= 32'd0;
            dst_q      <= 32'd0;
            len_q      <= 32'd0;
            next_q     <= 32'd0;
            beat_q     <= 2'd0;
            err_pend_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= 16'd0;
        end else begin
            ptr_q      <= ptr_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            next_q     <= next_d;
            beat_q     <= beat_d;
            err_pend_q <= err_pend_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    // Outputs: decoded from state or taken straight from registers
    always_comb begin
        done_o           = (state_q == StIdle);
        err_o            = err_q;
        desc_cnt_o       = cnt_q;
        bus.araddr_o     = {ptr_q, 4'b0000};
        bus.arlen_o      = 4'd3;
        bus.arsize_o     = 3'b010;
        bus.arburst_o    = 2'b01;
        bus.arvalid_o    = (state_q == StAr);
        bus.rready_o     = (state_q == StRd);
        bus.desc_valid_o = (state_q == StPush);
        bus.desc_src_o   = src_q;
        bus.desc_dst_o   = dst_q;
        bus.desc_len_o   = len_q;
    end

endmodule

// File: tb/tb_sgdmac_desc_fetch.sv
// Bench for sgdmac_desc_fetch: memory/AXI responder and engine model driven on the falling
// edge, a list-walk model that predicts AR addresses and pushed descriptors, and one compare
// process that checks the outputs one time unit after every rising edge.
module tb_sgdmac_desc_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [31:0] start_pointer_i;
    logic        done_o;
    logic        err_o;
    logic [15:0] desc_cnt_o;
    logic        engine_done_i;

    sgdmac_desc_fetch_if bus ();

    sgdmac_desc_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .start_pointer_i (start_pointer_i),
        .done_o          (done_o),
        .err_o           (err_o),
        .desc_cnt_o      (desc_cnt_o),
        .engine_done_i   (engine_done_i),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_ar [$];
    logic [95:0] exp_desc [$];

    bit          stall;
    bit          hold_ready;
    bit          hold_done;
    bit          inj_done;
    logic [31:0] err_addr;
    int          err_beat;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'd0;
    endfunction

    task automatic put(input logic [31:0] base, input logic [31:0] s, input logic [31:0] d,
                       input logic [31:0] l, input logic [31:0] n);
        mem[base]      = s;
        mem[base + 4]  = d;
        mem[base + 8]  = l;
        mem[base + 12] = n;
    endtask

    // List-walk model: which bursts are issued and which descriptors reach the engine.
    task automatic plan(input logic [31:0] p);
        logic [31:0] a;
        exp_ar.delete();
        exp_desc.delete();
        while (p != 32'd0) begin
            a = p & 32'hFFFF_FFF0;
            exp_ar.push_back(a);
            if (a == err_addr) break;
            if (rd(a + 8) != 32'd0) exp_desc.push_back({rd(a), rd(a + 4), rd(a + 8)});
            p = rd(a + 12);
        end
    endtask

    // AXI memory responder, one burst outstanding
    bit          r_busy;
    bit          r_fire;
    logic [31:0] r_base;
    int          r_beat;
    initial begin
        r_busy = 0; r_fire = 0; r_base = 0; r_beat = 0;
        bus.arready_i = 0; bus.rvalid_i = 0; bus.rdata_i = 0; bus.rresp_i = 0; bus.rlast_i = 0;
        forever begin
            @(negedge clk);
            if (r_fire) begin
                r_beat++;
                if (r_beat == 4) r_busy = 0;
            end
            if (r_busy) begin
                bus.rvalid_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.rdata_i  = rd(r_base + 32'(4 * r_beat));
                bus.rresp_i  = (r_base == err_addr && r_beat == err_beat) ? 2'b10 : 2'b00;
                bus.rlast_i  = (r_beat == 3);
            end else begin
                bus.rvalid_i = 0; bus.rresp_i = 0; bus.rlast_i = 0;
            end
            r_fire = bus.rvalid_i && bus.rready_o;
            bus.arready_i = !r_busy && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
            if (bus.arready_i && bus.arvalid_o) begin
                r_busy = 1; r_base = bus.araddr_o; r_beat = 0;
            end
        end
    end

    // Engine model
    bit eng_busy;
    int eng_wait;
    initial begin
        eng_busy = 0; eng_wait = 0;
        engine_done_i = 0; bus.desc_ready_i = 0;
        forever begin
            @(negedge clk);
            engine_done_i = 0;
            if (inj_done) begin
                engine_done_i = 1; inj_done = 0;
            end else if (eng_busy && !hold_done) begin
                if (eng_wait == 0) begin
                    engine_done_i = 1; eng_busy = 0;
                end else begin
                    eng_wait--;
                end
            end
            bus.desc_ready_i = !hold_ready && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
            if (bus.desc_ready_i && bus.desc_valid_o) begin
                eng_busy = 1; eng_wait = $urandom_range(0, 3);
            end
        end
    end

    // Compare process
    bit          p_arv, p_dv, p_done, p_rr, in_wait;
    logic [31:0] p_araddr, p_src, p_dst, p_len;
    int          exp_cnt;
    initial begin
        logic [95:0] e;
        p_arv = 0; p_dv = 0; p_done = 0; p_rr = 0; in_wait = 0; exp_cnt = 0;
        p_araddr = 0; p_src = 0; p_dst = 0; p_len = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                exp_cnt = 0; in_wait = 0;
                exp_ar.delete(); exp_desc.delete();
                chk("rst_done", done_o, 1);
                chk("rst_err", err_o, 0);
                chk("rst_cnt", desc_cnt_o, 0);
                chk("rst_arvalid", bus.arvalid_o, 0);
                chk("rst_rready", bus.rready_o, 0);
                chk("rst_desc_valid", bus.desc_valid_o, 0);
                chk("rst_araddr", bus.araddr_o, 0);
                chk("rst_src", bus.desc_src_o, 0);
                chk("rst_dst", bus.desc_dst_o, 0);
                chk("rst_len", bus.desc_len_o, 0);
            end else begin
                if (p_done && start_i) begin
                    exp_cnt = 0;
                    chk("start_err_clr", err_o, 0);
                    chk("start_arvalid", bus.arvalid_o, start_pointer_i != 0);
                    chk("start_done", done_o, start_pointer_i == 0);
                end
                if (p_arv) begin
                    if (bus.arready_i) begin
                        if (exp_ar.size() != 0) void'(exp_ar.pop_front());
                    end else begin
                        chk("ar_hold", bus.arvalid_o, 1);
                        chk("ar_stable", bus.araddr_o, p_araddr);
                    end
                end
                if (p_rr && bus.rvalid_i && bus.rlast_i)
                    chk("post_rlast", bus.desc_valid_o | bus.arvalid_o | done_o, 1);
                if (in_wait && engine_done_i) begin
                    chk("post_engine_done", bus.arvalid_o | done_o, 1);
                    in_wait = 0;
                end
                if (p_dv) begin
                    if (bus.desc_ready_i) begin
                        if (exp_desc.size() != 0) void'(exp_desc.pop_front());
                        if (exp_cnt < 65535) exp_cnt++;
                        in_wait = 1;
                        chk("dv_drop", bus.desc_valid_o, 0);
                    end else begin
                        chk("dv_hold", bus.desc_valid_o, 1);
                        chk("src_stable", bus.desc_src_o, p_src);
                        chk("dst_stable", bus.desc_dst_o, p_dst);
                        chk("len_stable", bus.desc_len_o, p_len);
                    end
                end
                chk("desc_cnt", desc_cnt_o, exp_cnt);
                chk("arlen", bus.arlen_o, 3);
                chk("arsize", bus.arsize_o, 3'b010);
                chk("arburst", bus.arburst_o, 2'b01);
                chk("idle_quiet", done_o & (bus.arvalid_o | bus.rready_o | bus.desc_valid_o), 0);
                if (bus.arvalid_o) begin
                    chk("ar_expected", exp_ar.size() != 0, 1);
                    if (exp_ar.size() != 0) chk("araddr", bus.araddr_o, exp_ar[0]);
                end
                if (bus.desc_valid_o) begin
                    chk("desc_expected", exp_desc.size() != 0, 1);
                    if (exp_desc.size() != 0) begin
                        e = exp_desc[0];
                        chk("desc_src", bus.desc_src_o, e[95:64]);
                        chk("desc_dst", bus.desc_dst_o, e[63:32]);
                        chk("desc_len", bus.desc_len_o, e[31:0]);
                    end
                end
            end
            p_arv = bus.arvalid_o; p_dv = bus.desc_valid_o; p_done = done_o;
            p_rr = bus.rready_o; p_araddr = bus.araddr_o;
            p_src = bus.desc_src_o; p_dst = bus.desc_dst_o; p_len = bus.desc_len_o;
        end
    end

    task automatic start(input logic [31:0] p);
        @(negedge clk);
        start_pointer_i = p;
        start_i = 1;
        @(negedge clk);
        start_i = 0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!done_o && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_finished"}, done_o, 1);
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst_n = 0; start_i = 0; start_pointer_i = 0;
        stall = 0; hold_ready = 0; hold_done = 0; inj_done = 0;
        err_addr = 32'hFFFF_FFF0; err_beat = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Single descriptor
        mem.delete();
        put(32'h100, 32'h1000, 32'h2000, 32'h40, 32'h0);
        plan(32'h100);
        start(32'h100);
        chk("t1_araddr", bus.araddr_o, 32'h100);
        chk("t1_arvalid", bus.arvalid_o, 1);
        chk("t1_done_low", done_o, 0);
        wait_done("t1");
        chk("t1_cnt", desc_cnt_o, 1);
        chk("t1_err", err_o, 0);
        chk("t1_left", exp_desc.size(), 0);

        // Three-descriptor chain with random stalls
        put(32'h100, 32'h1000, 32'h2000, 32'h40, 32'h200);
        put(32'h200, 32'h1100, 32'h2100, 32'h80, 32'h300);
        put(32'h300, 32'h1200, 32'h2200, 32'h10, 32'h0);
        stall = 1;
        plan(32'h100);
        start(32'h100);
        wait_done("t2");
        chk("t2_cnt", desc_cnt_o, 3);
        chk("t2_err", err_o, 0);
        chk("t2_left", exp_desc.size() + exp_ar.size(), 0);
        stall = 0;

        // Zero-length middle descriptor, unaligned start pointer
        put(32'h200, 32'h5, 32'h6, 32'h0, 32'h300);
        plan(32'h104);
        start(32'h104);
        chk("t3_araddr", bus.araddr_o, 32'h100);
        wait_done("t3");
        chk("t3_cnt", desc_cnt_o, 2);
        chk("t3_left", exp_desc.size() + exp_ar.size(), 0);

        // Read error on beat 2 of the second descriptor
        put(32'h200, 32'h1100, 32'h2100, 32'h80, 32'h300);
        err_addr = 32'h200; err_beat = 2;
        plan(32'h100);
        start(32'h100);
        wait_done("t4");
        chk("t4_err", err_o, 1);
        chk("t4_cnt", desc_cnt_o, 1);
        chk("t4_left", exp_desc.size() + exp_ar.size(), 0);
        err_addr = 32'hFFFF_FFF0;

        // Null pointer start: clears status, issues nothing
        plan(32'h0);
        start(32'h0);
        repeat (3) @(negedge clk);
        chk("t5_done", done_o, 1);
        chk("t5_err", err_o, 0);
        chk("t5_cnt", desc_cnt_o, 0);
        chk("t5_arvalid", bus.arvalid_o, 0);

        // Start while waiting on the engine is ignored
        hold_done = 1;
        plan(32'h300);
        start(32'h300);
        n = 0;
        while (!(desc_cnt_o == 16'd1 && !bus.desc_valid_o) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reached_wait", desc_cnt_o, 1);
        start(32'h100);
        @(negedge clk);
        chk("t6_no_ar", bus.arvalid_o, 0);
        chk("t6_busy", done_o, 0);
        hold_done = 0;
        wait_done("t6");
        chk("t6_cnt", desc_cnt_o, 1);

        // Stray engine_done while idle
        inj_done = 1;
        repeat (3) @(negedge clk);
        chk("t7_done", done_o, 1);
        chk("t7_arvalid", bus.arvalid_o, 0);
        chk("t7_cnt", desc_cnt_o, 1);

        // Reset while presenting a descriptor
        hold_ready = 1;
        plan(32'h300);
        start(32'h300);
        n = 0;
        while (!bus.desc_valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t8_in_push", bus.desc_valid_o, 1);
        rst_n = 0;
        @(negedge clk);
        chk("t8_dv", bus.desc_valid_o, 0);
        chk("t8_done", done_o, 1);
        chk("t8_cnt", desc_cnt_o, 0);
        rst_n = 1;
        hold_ready = 0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
